register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Parametrised multi-register storage block; generalises the single bus register to NUM_REGS entries.
//  One synchronous write port loads from the bus. Two asynchronous read ports feed the datapath operand muxes.
//  Optional hardwired-zero R0 and optional write-to-read bypass.
//  Sits between the bus (BusMuxOut) and the ALU/bus-input mux in the CPU datapath.
// PARAMETERS
//  DATA_WIDTH  32     width of each register and of the write/read data
//  NUM_REGS    16     number of registers; need not be a power of 2
//  ADDR_WIDTH  4      address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
//  ZERO_REG0   1      1: R0 reads 0 and ignores writes; 0: R0 is ordinary storage
//  BYPASS      0      1: a read of the address being written returns wr_data in the same cycle
//  INIT        32'h0  power-up value of every register (simulation/FPGA init only)
// PORTS
//  clock      in   1           rising-edge clock
//  clear      in   1           synchronous active-high reset
//  wr_en      in   1           write enable
//  wr_addr    in   ADDR_WIDTH  write address
//  BusMuxOut  in   DATA_WIDTH  write data from the bus
//  rd_addr_a  in   ADDR_WIDTH  read port A address
//  rd_addr_b  in   ADDR_WIDTH  read port B address
//  rd_data_a  out  DATA_WIDTH  read port A data
//  rd_data_b  out  DATA_WIDTH  read port B data
// BEHAVIOUR
//  - Power-up: every register holds INIT[DATA_WIDTH-1:0]. If ZERO_REG0=1, R0 still reads 0.
//  - clear=1 at posedge: every register becomes 0 next cycle. clear overrides wr_en; no write occurs.
//  - Reset value of the outputs: rd_data_a and rd_data_b read 0 in the cycle after clear, for any address.
//  - Write: at posedge, if clear=0, wr_en=1 and wr_addr is valid, then regs[wr_addr] <= BusMuxOut.
//  - A write is ignored when any of these holds:
//    - wr_addr >= NUM_REGS;
//    - wr_addr == 0 and ZERO_REG0=1;
//    - wr_en=0 (all registers hold their value).
//  - Read: combinational, zero-latency: rd_data_x = regs[rd_addr_x].
//  - Read returns 0 when:
//    - rd_addr_x >= NUM_REGS; or
//    - rd_addr_x == 0 and ZERO_REG0=1.
//  - Both read ports are independent. Both may address the same register in one cycle and both return its value.
//  - Without bypass (BYPASS=0): reading the address being written returns the old value this cycle and the new value from the next cycle.
//  - With bypass (BYPASS=1): if wr_en=1, clear=0, the write is valid and rd_addr_x==wr_addr, then rd_data_x = BusMuxOut in the same cycle.
//  - Bypass is never applied while clear=1, nor to an ignored write (R0 with ZERO_REG0=1, out-of-range address).
//  - Simultaneous write and two reads to one address: both ports obey the bypass rule identically.
//  - Back-to-back writes to the same address: the last write wins; each write becomes visible one cycle after its edge (BYPASS=0).
//  - No internal state beyond the register array. No handshake: a write always completes in one cycle.
// TESTING
//  - Write/read: write 0xDEADBEEF to R5, then rd_addr_a=5 -> rd_data_a=0xDEADBEEF next cycle.
//    Other registers are unchanged (check R4 and R6).
//  - R0 and range (ZERO_REG0=1, NUM_REGS=12):
//    - write 0x1234 to R0 -> rd_data_a=0 for R0;
//    - write to address 13 -> no register changes, and reading 13 returns 0.
//  - Bypass: write 0xA5A5A5A5 to R3, rd_addr_a=rd_addr_b=3 in the same cycle:
//    - BYPASS=1 -> both ports read 0xA5A5A5A5 that cycle;
//    - BYPASS=0 -> both ports read the old value that cycle and 0xA5A5A5A5 the next.
//  - Clear priority: fill R1..R15 with nonzero values, then assert clear together with wr_en (R7=0xFF):
//    - next cycle, all reads are 0 and R7=0;
//    - rd_data is not bypassed during the clear cycle.
//  - Back-to-back and dual port: write R2=1 then R2=2 on consecutive cycles -> R2=2.
//    Concurrent reads of R2 and R9 on ports A and B return the correct independent values every cycle.

Source files
------------

// File: rtl/register_file.sv
// Parametrised register array: one synchronous write port from the bus and two
// combinational read ports, with optional hardwired-zero R0 and write-to-read bypass.
module register_file #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 16,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    ZERO_REG0  = 1,
   parameter int                    BYPASS     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] BusMuxOut,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b
);

   // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam bit                  LP_ZERO_R0  = (ZERO_REG0 != 0);
   localparam bit                  LP_BYPASS   = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS] = '{default: INIT};

   logic w_wr_in_range;
   logic w_wr_is_r0;
   logic w_wr_valid;
   logic w_byp_a;
   logic w_byp_b;
   logic [DATA_WIDTH-1:0] w_arr_a;
   logic [DATA_WIDTH-1:0] w_arr_b;

   // A write that is dropped here is also never bypassed, so both paths share this.
   assign w_wr_in_range = ({1'b0, wr_addr} < LP_NUM_REGS);
   assign w_wr_is_r0    = LP_ZERO_R0 && (wr_addr == '0);
   assign w_wr_valid    = wr_en && !clear && w_wr_in_range && !w_wr_is_r0;

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_valid && (wr_addr == ADDR_WIDTH'(i))) begin
               r_regs[i] <= BusMuxOut;
            end
         end
      end
   end

   // Out-of-range addresses and a hardwired R0 fall through to the zero default.
   function automatic logic [DATA_WIDTH-1:0] f_lookup(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ((addr == ADDR_WIDTH'(i)) && !(LP_ZERO_R0 && (i == 0))) begin
            res = r_regs[i];
         end
      end
      return res;
   endfunction

   always_comb begin
      w_arr_a = f_lookup(rd_addr_a);
      w_arr_b = f_lookup(rd_addr_b);
   end

   assign w_byp_a = LP_BYPASS && w_wr_valid && (rd_addr_a == wr_addr);
   assign w_byp_b = LP_BYPASS && w_wr_valid && (rd_addr_b == wr_addr);

   assign rd_data_a = w_byp_a ? BusMuxOut : w_arr_a;
   assign rd_data_b = w_byp_b ? BusMuxOut : w_arr_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three configurations share one input set
// (16 regs/no bypass, 16 regs/ordinary R0/bypass, 12 regs/bypass).
module tb_register_file;

   logic        clk;
   logic        clear;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] bus;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [31:0] d0_a, d0_b, d1_a, d1_b, d2_a, d2_b;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        c;
      logic        we;
      logic [3:0]  wa;
      logic [31:0] d;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   vec_t vecs[18];

   register_file #(.NUM_REGS(16), .ZERO_REG0(1), .BYPASS(0)) dut0 (
      .clock(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .BusMuxOut(bus),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(d0_a), .rd_data_b(d0_b));

   register_file #(.NUM_REGS(16), .ZERO_REG0(0), .BYPASS(1)) dut1 (
      .clock(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .BusMuxOut(bus),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(d1_a), .rd_data_b(d1_b));

   register_file #(.NUM_REGS(12), .ZERO_REG0(1), .BYPASS(1)) dut2 (
      .clock(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .BusMuxOut(bus),
      .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(d2_a), .rd_data_b(d2_b));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: inputs change at negedge, outputs are sampled 1 ns later
   task automatic set_in(input logic c, input logic we, input logic [3:0] wa,
                         input logic [31:0] d, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      clear   = c;
      wr_en   = we;
      wr_addr = wa;
      bus     = d;
      ra      = a;
      rb      = b;
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // contents after the fill sequence: R(i) = 0x100+i unless hardwired or absent
   function automatic logic [31:0] fill_val(input int i, input int num, input bit zero0);
      if (i >= num || (zero0 && i == 0)) return 32'h0;
      if (i == 0) return 32'h0;
      return 32'h100 + 32'(i);
   endfunction

   initial begin
      clear = 1'b0; wr_en = 1'b0; wr_addr = '0; bus = '0; ra = '0; rb = '0;

      // c  we  wa  data  ra  rb  exp_a  exp_b  (dut0: 16 regs, zero R0, no bypass)
      vecs[0]  = '{1'b1, 1'b1, 4'd7,  32'hFF,       4'd7,  4'd0,  32'h0,        32'h0};
      vecs[1]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd3,  4'd15, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 1'b1, 4'd5,  32'hDEADBEEF, 4'd5,  4'd4,  32'h0,        32'h0};
      vecs[3]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd5,  4'd6,  32'hDEADBEEF, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd4,  4'd5,  32'h0,        32'hDEADBEEF};
      vecs[5]  = '{1'b0, 1'b1, 4'd0,  32'h1234,     4'd0,  4'd5,  32'h0,        32'hDEADBEEF};
      vecs[6]  = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd0,  4'd0,  32'h0,        32'h0};
      vecs[7]  = '{1'b0, 1'b1, 4'd2,  32'h1,        4'd2,  4'd9,  32'h0,        32'h0};
      vecs[8]  = '{1'b0, 1'b1, 4'd2,  32'h2,        4'd2,  4'd9,  32'h1,        32'h0};
      vecs[9]  = '{1'b0, 1'b1, 4'd9,  32'h9999,     4'd2,  4'd9,  32'h2,        32'h0};
      vecs[10] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd2,  4'd9,  32'h2,        32'h9999};
      vecs[11] = '{1'b0, 1'b1, 4'd3,  32'hA5A5A5A5, 4'd3,  4'd3,  32'h0,        32'h0};
      vecs[12] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd3,  4'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[13] = '{1'b0, 1'b1, 4'd15, 32'hCAFEF00D, 4'd15, 4'd3,  32'h0,        32'hA5A5A5A5};
      vecs[14] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd15, 4'd5,  32'hCAFEF00D, 32'hDEADBEEF};
      vecs[15] = '{1'b1, 1'b1, 4'd7,  32'hFF,       4'd5,  4'd7,  32'hDEADBEEF, 32'h0};
      vecs[16] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd7,  4'd5,  32'h0,        32'h0};
      vecs[17] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd15, 4'd3,  32'h0,        32'h0};

      for (int k = 0; k < 18; k++) begin
         set_in(vecs[k].c, vecs[k].we, vecs[k].wa, vecs[k].d, vecs[k].ra, vecs[k].rb);
         check($sformatf("vec%0d_a", k), d0_a, vecs[k].ea);
         check($sformatf("vec%0d_b", k), d0_b, vecs[k].eb);
      end

      // fill R1..R15, then read back every address on all three configurations
      set_in(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
      for (int i = 1; i < 16; i++) set_in(1'b0, 1'b1, 4'(i), 32'h100 + 32'(i), 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i));
         check($sformatf("fill_d0_a%0d", i), d0_a, fill_val(i, 16, 1'b1));
         check($sformatf("fill_d0_b%0d", 15 - i), d0_b, fill_val(15 - i, 16, 1'b1));
         check($sformatf("fill_d1_a%0d", i), d1_a, fill_val(i, 16, 1'b0));
         check($sformatf("fill_d2_a%0d", i), d2_a, fill_val(i, 12, 1'b1));
      end

      // clear together with a write of R7: no bypass in the clear cycle
      set_in(1'b1, 1'b1, 4'd7, 32'hFF, 4'd7, 4'd7);
      check("clr_cyc_d0_a", d0_a, 32'h107);
      check("clr_cyc_d1_a", d1_a, 32'h107);
      check("clr_cyc_d1_b", d1_b, 32'h107);
      check("clr_cyc_d2_a", d2_a, 32'h107);
      for (int i = 0; i < 16; i++) begin
         set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'(i), 4'(i));
         check($sformatf("clr_d0_a%0d", i), d0_a, 32'h0);
         check($sformatf("clr_d1_b%0d", i), d1_b, 32'h0);
         check($sformatf("clr_d2_a%0d", i), d2_a, 32'h0);
      end

      // same-cycle write and dual read of R3
      set_in(1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 4'd3, 4'd3);
      check("byp_d0_a", d0_a, 32'h0);
      check("byp_d0_b", d0_b, 32'h0);
      check("byp_d1_a", d1_a, 32'hA5A5A5A5);
      check("byp_d1_b", d1_b, 32'hA5A5A5A5);
      check("byp_d2_a", d2_a, 32'hA5A5A5A5);
      check("byp_d2_b", d2_b, 32'hA5A5A5A5);
      set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
      check("after_byp_d0_a", d0_a, 32'hA5A5A5A5);
      check("after_byp_d0_b", d0_b, 32'hA5A5A5A5);

      // R0 write: bypassed only where R0 is ordinary storage
      set_in(1'b0, 1'b1, 4'd0, 32'h1234, 4'd0, 4'd0);
      check("r0_byp_d1", d1_a, 32'h1234);
      check("r0_byp_d0", d0_a, 32'h0);
      check("r0_byp_d2", d2_a, 32'h0);
      set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
      check("r0_d1", d1_a, 32'h1234);
      check("r0_d0", d0_a, 32'h0);
      check("r0_d2", d2_a, 32'h0);

      // address 13: out of range for the 12-register configuration
      set_in(1'b0, 1'b1, 4'd13, 32'h77, 4'd13, 4'd4);
      check("oor_byp_d2", d2_a, 32'h0);
      check("oor_byp_d1", d1_a, 32'h77);
      check("oor_old_d0", d0_a, 32'h0);
      set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'd13, 4'd3);
      check("oor_d2_a", d2_a, 32'h0);
      check("oor_d2_b", d2_b, 32'hA5A5A5A5);
      check("oor_d0_a", d0_a, 32'h77);
      set_in(1'b0, 1'b0, 4'd0, 32'h0, 4'd1, 4'd11);
      check("oor_d2_r1", d2_a, 32'h0);
      check("oor_d2_r11", d2_b, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
